// File: rtl/axi4_mem_responder.sv
// axi4_mem_responder: AXI4 slave backed by on-chip RAM, with independent single-outstanding read and write FSMs
module axi4_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH = 1,
    parameter int MEM_ADDR_BITS = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                    uncoreclk,
    input  logic                    uncorerst,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB = $clog2(STRB_W);
    localparam int IDX_W = MEM_ADDR_BITS - LSB;
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} r_state_t;

    logic [DATA_WIDTH-1:0] mem [2**IDX_W];

    w_state_t w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0] wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0] wsize_q, wsize_d;
    logic [1:0] wburst_q, wburst_d, werr_q, werr_d, bresp_q, bresp_d;
    logic [ID_WIDTH-1:0] bid_q, bid_d;
    logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic mem_we;
    logic [IDX_W-1:0] w_idx;

    r_state_t r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0] rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0] rsize_q, rsize_d;
    logic [1:0] rburst_q, rburst_d, rerr_q, rerr_d, rresp_q, rresp_d;
    logic [ID_WIDTH-1:0] rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [IDX_W-1:0] r_idx;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return ((a - BASE_ADDR) >> MEM_ADDR_BITS) == '0;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> LSB);
    endfunction

    // Start-address decode wins over burst-shape errors
    function automatic logic [1:0] classify(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
        logic bad_wrap;
        bad_wrap = burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return !in_range(a) ? DECERR : (burst == 2'b11 || size > 3'(LSB) || bad_wrap) ? SLVERR : OKAY;
    endfunction

    // A clean burst can still run off the top of the RAM; those beats alone decode-error
    function automatic logic [1:0] beat_resp(input logic [1:0] err, input logic [ADDR_WIDTH-1:0] a);
        return err != OKAY ? err : in_range(a) ? OKAY : DECERR;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] len,
                                                        input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] inc, mask;
        inc = ONE << size;
        mask = ((ADDR_WIDTH'(len) + ONE) << size) - ONE;
        return burst == 2'b00 ? a : burst == 2'b10 ? ((a & ~mask) | ((a + inc) & mask)) : a + inc;
    endfunction

    assign w_idx = word_idx(waddr_q);
    assign r_idx = word_idx(raddr_q);

    // Write channel: next state, burst bookkeeping and accumulated response
    always_comb begin
        w_state_d = w_state_q;
        waddr_d = waddr_q;
        wlen_d = wlen_q;
        wsize_d = wsize_q;
        wburst_d = wburst_q;
        werr_d = werr_q;
        wcnt_d = wcnt_q;
        bid_d = bid_q;
        bresp_d = bresp_q;
        mem_we = 1'b0;
        case (w_state_q)
            W_IDLE: if (s_axi_awvalid && awready_q) begin
                waddr_d = s_axi_awaddr;
                wlen_d = s_axi_awlen;
                wsize_d = s_axi_awsize;
                wburst_d = s_axi_awburst;
                werr_d = classify(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
                bresp_d = werr_d;
                bid_d = s_axi_awid;
                wcnt_d = 8'd0;
                w_state_d = W_DATA;
            end
            W_DATA: if (s_axi_wvalid && wready_q) begin
                mem_we = werr_q == OKAY && in_range(waddr_q);
                if (werr_q == OKAY && !in_range(waddr_q)) bresp_d = DECERR;
                if (s_axi_wlast != (wcnt_q == wlen_q) && bresp_d != DECERR) bresp_d = SLVERR;
                waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                wcnt_d = wcnt_q + 8'd1;
                w_state_d = wcnt_q == wlen_q ? W_RESP : W_DATA;
            end
            W_RESP: if (s_axi_bready && bvalid_q) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        awready_d = w_state_d == W_IDLE;
        wready_d = w_state_d == W_DATA;
        bvalid_d = w_state_d == W_RESP;
    end

    // Write channel registers
    always_ff @(posedge uncoreclk or posedge uncorerst) begin
        if (uncorerst) begin
            w_state_q <= W_IDLE;
            waddr_q <= '0;
            wlen_q <= '0;
            wsize_q <= '0;
            wburst_q <= '0;
            werr_q <= '0;
            wcnt_q <= '0;
            bid_q <= '0;
            bresp_q <= '0;
            awready_q <= 1'b0;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q <= waddr_d;
            wlen_q <= wlen_d;
            wsize_q <= wsize_d;
            wburst_q <= wburst_d;
            werr_q <= werr_d;
            wcnt_q <= wcnt_d;
            bid_q <= bid_d;
            bresp_q <= bresp_d;
            awready_q <= awready_d;
            wready_q <= wready_d;
            bvalid_q <= bvalid_d;
        end
    end

    // RAM write port, byte-enabled; contents survive reset
    always_ff @(posedge uncoreclk) begin
        if (mem_we)
            for (int b = 0; b < STRB_W; b++)
                if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
    end

    // Read channel: next state; the fetch cycle samples the RAM before any same-edge write lands
    always_comb begin
        r_state_d = r_state_q;
        raddr_d = raddr_q;
        rlen_d = rlen_q;
        rsize_d = rsize_q;
        rburst_d = rburst_q;
        rerr_d = rerr_q;
        rcnt_d = rcnt_q;
        rid_d = rid_q;
        rresp_d = rresp_q;
        rdata_d = rdata_q;
        rlast_d = rlast_q;
        case (r_state_q)
            R_IDLE: if (s_axi_arvalid && arready_q) begin
                raddr_d = s_axi_araddr;
                rlen_d = s_axi_arlen;
                rsize_d = s_axi_arsize;
                rburst_d = s_axi_arburst;
                rerr_d = classify(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
                rid_d = s_axi_arid;
                rcnt_d = 8'd0;
                r_state_d = R_FETCH;
            end
            R_FETCH: begin
                rresp_d = beat_resp(rerr_q, raddr_q);
                rdata_d = rresp_d == OKAY ? mem[r_idx] : '0;
                rlast_d = rcnt_q == rlen_q;
                r_state_d = R_SEND;
            end
            R_SEND: if (s_axi_rready && rvalid_q) begin
                rlast_d = 1'b0;
                raddr_d = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
                rcnt_d = rcnt_q + 8'd1;
                r_state_d = rlast_q ? R_IDLE : R_FETCH;
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = r_state_d == R_IDLE;
        rvalid_d = r_state_d == R_SEND;
    end

    // Read channel registers
    always_ff @(posedge uncoreclk or posedge uncorerst) begin
        if (uncorerst) begin
            r_state_q <= R_IDLE;
            raddr_q <= '0;
            rlen_q <= '0;
            rsize_q <= '0;
            rburst_q <= '0;
            rerr_q <= '0;
            rcnt_q <= '0;
            rid_q <= '0;
            rresp_q <= '0;
            rdata_q <= '0;
            rlast_q <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            raddr_q <= raddr_d;
            rlen_q <= rlen_d;
            rsize_q <= rsize_d;
            rburst_q <= rburst_d;
            rerr_q <= rerr_d;
            rcnt_q <= rcnt_d;
            rid_q <= rid_d;
            rresp_q <= rresp_d;
            rdata_q <= rdata_d;
            rlast_q <= rlast_d;
            arready_q <= arready_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready = wready_q;
    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bid = bid_q;
    assign s_axi_bresp = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rid = rid_q;
    assign s_axi_rdata = rdata_q;
    assign s_axi_rresp = rresp_q;
    assign s_axi_rlast = rlast_q;
endmodule

// File: tb/tb_axi4_mem_responder.sv
// tb_axi4_mem_responder: scoreboard bench for the AXI4 memory responder
module tb_axi4_mem_responder;
    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;
    typedef struct packed {
        logic       id;
        logic [1:0] resp;
    } bexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic awid = 1'b0, awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [7:0] awlen = '0, arlen = '0, wstrb = '0;
    logic [2:0] awsize = '0, arsize = '0;
    logic [1:0] awburst = '0, arburst = '0;
    logic [63:0] wdata = '0;
    logic arid = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic awready, wready, bid, bvalid, arready, rid, rlast, rvalid;
    logic [1:0] bresp, rresp;
    logic [63:0] rdata;

    int checks = 0;
    int errors = 0;
    rbeat_t rq[$];
    bexp_t bq[$];
    logic [63:0] model [8192];
    logic [63:0] wd [16];
    logic [7:0] ws [16];

    always #5 clk = ~clk;

    axi4_mem_responder dut (
        .uncoreclk(clk), .uncorerst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
        .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    function automatic logic m_in(input logic [31:0] a);
        return a >= BASE && {1'b0, a} < {1'b0, BASE} + 33'h1_0000;
    endfunction

    function automatic logic [12:0] m_idx(input logic [31:0] a);
        return 13'((a - BASE) >> 3);
    endfunction

    function automatic logic [1:0] m_class(input logic [31:0] a, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst);
        if (!m_in(a)) return 2'b11;
        if (burst == 2'b11 || size > 3'd3) return 2'b10;
        if (burst == 2'b10 && len != 8'd1 && len != 8'd3 && len != 8'd7 && len != 8'd15) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] a, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst);
        longint unsigned step, bytes, lo, nxt;
        step = longint'(1) << size;
        nxt = longint'(a) + step;
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            bytes = (longint'(len) + 1) * step;
            lo = longint'(a) - (longint'(a) % bytes);
            return nxt >= lo + bytes ? 32'(lo) : 32'(nxt);
        end
        return 32'(nxt);
    endfunction

    task automatic do_write(input logic id, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int last_at, input bit bp);
        logic [31:0] a;
        logic [1:0] cls, resp;
        logic [2:0] hold;
        bexp_t e;
        bit held;
        int n;
        a = addr;
        cls = m_class(addr, len, size, burst);
        resp = cls;
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        wdata = wd[0]; wstrb = ws[0]; wlast = last_at == 0; wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 20);
        if (!awready) begin
            checks++; errors++;
            $display("FAIL aw_timeout addr=%h awready=%b required 1", addr, awready);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wd[i]; wstrb = ws[i]; wlast = i == last_at;
            n = 0;
            do begin @(negedge clk); n++; end while (!wready && n < 20);
            if (!wready) begin
                checks++; errors++;
                $display("FAIL w_timeout beat=%0d wready=%b required 1", i, wready);
                wvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (cls == 2'b00 && m_in(a)) begin
                for (int b = 0; b < 8; b++)
                    if (ws[i][b]) model[m_idx(a)][b*8 +: 8] = wd[i][b*8 +: 8];
            end else if (cls == 2'b00) resp = 2'b11;
            if ((i == last_at) != (i == int'(len)) && resp != 2'b11) resp = 2'b10;
            a = m_next(a, len, size, burst);
        end
        wvalid = 1'b0; wlast = 1'b0;
        e.id = id; e.resp = resp;
        bq.push_back(e);
        bready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        held = 0; hold = '0; n = 0;
        while (1) begin
            @(negedge clk); n++;
            if (held) begin
                checks++;
                if ({bvalid, bid, bresp} !== {1'b1, hold}) begin
                    errors++;
                    $display("FAIL b_stable got v=%b id=%b resp=%b required v=1 id=%b resp=%b",
                             bvalid, bid, bresp, hold[2], hold[1:0]);
                end
                held = 0;
            end
            if (bvalid && bready) begin
                e = bq.pop_front();
                checks++;
                if ({bid, bresp} !== {e.id, e.resp}) begin
                    errors++;
                    $display("FAIL bresp addr=%h got id=%b resp=%b required id=%b resp=%b",
                             addr, bid, bresp, e.id, e.resp);
                end
                @(posedge clk); #1;
                bready = 1'b0;
                break;
            end
            if (bvalid) begin held = 1; hold = {bid, bresp}; end
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL b_timeout bvalid=%b required 1", bvalid);
                bready = 1'b0;
                void'(bq.pop_front());
                break;
            end
            @(posedge clk); #1;
            bready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic do_read(input logic id, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit bp, input bit check_lat, input int abort_after);
        logic [31:0] a;
        logic [1:0] cls;
        rbeat_t e;
        logic [67:0] hold;
        bit held, lat_done;
        int n, beats;
        a = addr;
        cls = m_class(addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            e.resp = cls != 2'b00 ? cls : m_in(a) ? 2'b00 : 2'b11;
            e.data = e.resp == 2'b00 ? model[m_idx(a)] : 64'h0;
            e.last = i == int'(len);
            rq.push_back(e);
            a = m_next(a, len, size, burst);
        end
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!arready && n < 20);
        if (!arready) begin
            checks++; errors++;
            $display("FAIL ar_timeout addr=%h arready=%b required 1", addr, arready);
            arvalid = 1'b0;
            rq.delete();
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        rready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        beats = 0; n = 0; held = 0; hold = '0; lat_done = 0;
        while (beats <= int'(len)) begin
            @(negedge clk); n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL r_timeout addr=%h beats=%0d required %0d", addr, beats, int'(len) + 1);
                rq.delete();
                break;
            end
            if (held) begin
                checks++;
                if ({rvalid, rid, rdata, rresp, rlast} !== {1'b1, hold}) begin
                    errors++;
                    $display("FAIL r_stable got v=%b data=%h resp=%b last=%b required v=1 data=%h resp=%b last=%b",
                             rvalid, rdata, rresp, rlast, hold[66:3], hold[2:1], hold[0]);
                end
                held = 0;
            end
            if (rvalid && check_lat && !lat_done) begin
                lat_done = 1;
                checks++;
                if (n != 2) begin
                    errors++;
                    $display("FAIL r_latency got %0d cycles required 2", n);
                end
            end
            if (rvalid && beats == abort_after) return;
            if (rvalid && rready) begin
                e = rq.pop_front();
                checks++;
                if ({rid, rdata, rresp, rlast} !== {id, e.data, e.resp, e.last}) begin
                    errors++;
                    $display("FAIL rbeat addr=%h beat=%0d got id=%b data=%h resp=%b last=%b required id=%b data=%h resp=%b last=%b",
                             addr, beats, rid, rdata, rresp, rlast, id, e.data, e.resp, e.last);
                end
                beats++;
            end else if (rvalid) begin
                held = 1;
                hold = {rid, rdata, rresp, rlast};
            end
            @(posedge clk); #1;
            rready = beats == abort_after ? 1'b0 : bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        rready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 000000", {awready, wready, bvalid, arready, rvalid, rlast});
        end
        checks++;
        if ({bresp, bid, rresp, rid, rdata} !== 70'h0) begin
            errors++;
            $display("FAIL reset_payload got bresp=%b bid=%b rresp=%b rid=%b rdata=%h required all 0",
                     bresp, bid, rresp, rid, rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({awready, arready, wready, bvalid, rvalid} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_release got %b required 11000", {awready, arready, wready, bvalid, rvalid});
        end
    endtask

    task automatic test_single();
        wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
        do_write(1'b1, BASE + 32'h10, 8'd0, 3'd3, 2'b01, 0, 0);
        do_read(1'b1, BASE + 32'h10, 8'd0, 3'd3, 2'b01, 0, 1, -1);
    endtask

    task automatic test_incr_strobe();
        for (int i = 0; i < 4; i++) begin
            wd[i] = {32'hA5A5_0000 | 32'(i), 32'h1234_5670 + 32'(i)};
            ws[i] = 8'hFF;
        end
        do_write(1'b0, BASE + 32'h100, 8'd3, 3'd3, 2'b01, 3, 0);
        for (int i = 0; i < 4; i++) wd[i] = ~wd[i];
        ws[2] = 8'h0F;
        do_write(1'b1, BASE + 32'h100, 8'd3, 3'd3, 2'b01, 3, 1);
        do_read(1'b1, BASE + 32'h100, 8'd3, 3'd3, 2'b01, 1, 0, -1);
        do_read(1'b0, BASE + 32'h100, 8'd3, 3'd3, 2'b01, 1, 0, -1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) begin
            wd[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
            ws[i] = 8'hFF;
        end
        do_write(1'b0, BASE + 32'h218, 8'd3, 3'd3, 2'b10, 3, 0);
        do_read(1'b0, BASE + 32'h200, 8'd3, 3'd3, 2'b01, 0, 0, -1);
        do_read(1'b1, BASE + 32'h218, 8'd3, 3'd3, 2'b10, 1, 0, -1);
    endtask

    task automatic test_errors();
        wd[0] = 64'hDEAD_BEEF_0BAD_F00D; ws[0] = 8'hFF;
        do_write(1'b0, BASE + 32'hFFF8, 8'd0, 3'd3, 2'b01, 0, 0);
        wd[0] = 64'h0123_4567_89AB_CDEF;
        do_write(1'b1, 32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 0, 0);
        do_read(1'b0, BASE + 32'hFFF8, 8'd0, 3'd3, 2'b01, 0, 0, -1);
        do_read(1'b1, BASE + 32'hFFF8, 8'd1, 3'd3, 2'b01, 0, 0, -1);
        do_read(1'b1, BASE + 32'h10, 8'd1, 3'd3, 2'b11, 0, 0, -1);
        do_read(1'b0, BASE + 32'h200, 8'd2, 3'd3, 2'b10, 0, 0, -1);
        do_read(1'b0, BASE + 32'h200, 8'd0, 3'd4, 2'b01, 0, 0, -1);
        do_read(1'b1, 32'h9000_0000, 8'd0, 3'd3, 2'b01, 0, 0, -1);
        for (int i = 0; i < 3; i++) begin
            wd[i] = 64'h5A5A_0000_0000_0000 | 64'(i);
            ws[i] = 8'hFF;
        end
        do_write(1'b0, BASE + 32'h300, 8'd2, 3'd3, 2'b01, 1, 0);
    endtask

    task automatic test_reset_mid_read();
        do_read(1'b0, BASE + 32'h100, 8'd3, 3'd3, 2'b01, 0, 0, 1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rvalid, arready, rlast} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_async got rvalid/arready/rlast=%b required 000", {rvalid, arready, rlast});
        end
        rq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (arready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_arready got %b required 1", arready);
        end
        do_read(1'b1, BASE + 32'h100, 8'd3, 3'd3, 2'b01, 1, 1, -1);
    endtask

    task automatic test_concurrent();
        wd[0] = 64'hAAAA_AAAA_1111_1111; ws[0] = 8'hFF;
        do_write(1'b0, BASE + 32'h400, 8'd0, 3'd3, 2'b01, 0, 0);
        wd[0] = 64'h5555_5555_2222_2222;
        fork
            do_write(1'b1, BASE + 32'h400, 8'd0, 3'd3, 2'b01, 0, 0);
            do_read(1'b0, BASE + 32'h400, 8'd0, 3'd3, 2'b01, 0, 1, -1);
        join
        do_read(1'b1, BASE + 32'h400, 8'd0, 3'd3, 2'b01, 0, 0, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_incr_strobe();
        test_wrap();
        test_errors();
        test_reset_mid_read();
        test_concurrent();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
